// File: rtl/store_buffer_if.sv
// Core-side load/store request and data-memory port of the store buffer, bundled as one interface.
// master drives the requests and the memory read data; slave is the store buffer itself.
interface store_buffer_if;
  logic        mem_read;
  logic        mem_write;
  logic        flush;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        data_read_flag;
  logic        data_write_flag;
  logic [31:0] data_addr;
  logic [31:0] val;
  logic [31:0] read_out;

  modport master (
    output mem_read, mem_write, flush, addr, wdata, read_out,
    input  rdata, stall, data_read_flag, data_write_flag, data_addr, val
  );

  modport slave (
    input  mem_read, mem_write, flush, addr, wdata, read_out,
    output rdata, stall, data_read_flag, data_write_flag, data_addr, val
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-store FIFO in front of a single-port word memory; drains whenever the port is free.
// Define SB_FORWARD_EN to forward loads from buffered stores; otherwise matching loads stall.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 5
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [IDX_W-1:0] idx_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;

  logic [IDX_W-1:0] req_idx;
  logic             full, empty, load, hit, ld_stall;
  logic             drain, enq, port_load;

  assign req_idx = bus.addr[IDX_W+1:2];
  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign load    = bus.mem_read && !bus.mem_write;

`ifdef SB_FORWARD_EN
  logic [31:0] fwd_data;

  // Oldest to youngest, so the last match left standing is the youngest store.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (CntW'(i) < count_q && idx_q[head_q + PtrW'(i)] == req_idx) begin
        hit      = 1'b1;
        fwd_data = data_q[head_q + PtrW'(i)];
      end
    end
  end

  assign ld_stall = 1'b0;
`else
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (CntW'(i) < count_q && idx_q[head_q + PtrW'(i)] == req_idx) begin
        hit = 1'b1;
      end
    end
  end

  assign ld_stall = load && hit;
`endif

  assign bus.stall = (bus.mem_write && full) || (bus.flush && !empty) || ld_stall;
  // A stalled request never uses the port, so the drain gets it even with mem_read high.
  assign drain     = !empty && (!bus.mem_read || bus.stall);
  assign enq       = bus.mem_write && !bus.stall;
  assign port_load = load && !drain;

  always_comb begin
    bus.data_read_flag  = port_load;
    bus.data_write_flag = drain;
    bus.data_addr       = '0;
    bus.val             = '0;
    if (drain) begin
      bus.data_addr = 32'({idx_q[head_q], 2'b00});
      bus.val       = data_q[head_q];
    end else if (port_load) begin
      bus.data_addr = bus.addr;
    end
  end

`ifdef SB_FORWARD_EN
  always_comb begin
    bus.rdata = '0;
    if (load) begin
      if (hit) begin
        bus.rdata = fwd_data;
      end else if (port_load) begin
        bus.rdata = bus.read_out;
      end
    end
  end
`else
  assign bus.rdata = port_load ? bus.read_out : '0;
`endif

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    head_d  = drain ? head_q + 1'b1 : head_q;
    tail_d  = enq ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CntW'(enq) - CntW'(drain);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      idx_q[tail_q]  <= req_idx;
      data_q[tail_q] <= bus.wdata;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: per-cycle vector table, hand sequences, and a write-order scoreboard.
// Expectations for the load-match sequence follow SB_FORWARD_EN as defined for the build.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDX_W = 5;

  logic clk = 1'b0;
  logic rst;
  store_buffer_if bus ();

  store_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory model: unwritten words read back as A000_00xx so forwarded data is distinguishable.
  logic [31:0] mem_m [32];
  logic [31:0] wr_mask = '0;
  logic [4:0]  rd_idx;
  assign rd_idx       = bus.data_addr[6:2];
  assign bus.read_out = wr_mask[rd_idx] ? mem_m[rd_idx] : (32'hA000_0000 | 32'(rd_idx));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [31:0]      data;
  } ent_t;
  ent_t sb_q[$];

  // Scoreboard: accepted stores are pushed, memory writes must pop them in FIFO order.
  always @(negedge clk) begin
    ent_t e;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (bus.data_write_flag) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_write: got addr %h val %h expected no write",
                   bus.data_addr, bus.val);
        end else begin
          e = sb_q.pop_front();
          chk("sb_addr", bus.data_addr, 32'({e.idx, 2'b00}));
          chk("sb_val", bus.val, e.data);
        end
        mem_m[bus.data_addr[6:2]]   = bus.val;
        wr_mask[bus.data_addr[6:2]] = 1'b1;
      end
      if (bus.mem_write && !bus.stall) begin
        e.idx  = bus.addr[IDX_W+1:2];
        e.data = bus.wdata;
        sb_q.push_back(e);
      end
    end
  end

  typedef struct {
    logic        rd, wr, fl;
    logic [31:0] a, d;
    logic        stall, drf, dwf;
    logic [31:0] daddr, val, rdata;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic fl,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic stall, input logic drf, input logic dwf,
                              input logic [31:0] daddr, input logic [31:0] val,
                              input logic [31:0] rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.fl = fl; v.a = a; v.d = d;
    v.stall = stall; v.drf = drf; v.dwf = dwf;
    v.daddr = daddr; v.val = val; v.rdata = rdata;
    return v;
  endfunction

  // Drive at posedge+1, leave outputs to settle, return at posedge+3 for sampling.
  task automatic drive(input logic rd, input logic wr, input logic fl,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.flush     = fl;
    bus.addr      = a;
    bus.wdata     = d;
    #2;
  endtask

  task automatic chk_all(input string tag, input logic stall, input logic drf, input logic dwf,
                         input logic [31:0] daddr, input logic [31:0] val,
                         input logic [31:0] rdata);
    chk({tag, "_stall"}, 32'(bus.stall), 32'(stall));
    chk({tag, "_drf"}, 32'(bus.data_read_flag), 32'(drf));
    chk({tag, "_dwf"}, 32'(bus.data_write_flag), 32'(dwf));
    chk({tag, "_daddr"}, bus.data_addr, daddr);
    chk({tag, "_val"}, bus.val, val);
    chk({tag, "_rdata"}, bus.rdata, rdata);
  endtask

  vec_t tbl [18];

  initial begin
    tbl[0]  = mk(0, 0, 0, 32'h00, 32'h000, 0, 0, 0, 32'h00, 32'h000, 32'h0);
    tbl[1]  = mk(0, 1, 0, 32'h08, 32'h011, 0, 0, 0, 32'h00, 32'h000, 32'h0);
    tbl[2]  = mk(0, 0, 0, 32'h00, 32'h000, 0, 0, 1, 32'h08, 32'h011, 32'h0);
    tbl[3]  = mk(0, 0, 0, 32'h00, 32'h000, 0, 0, 0, 32'h00, 32'h000, 32'h0);
    tbl[4]  = mk(1, 0, 0, 32'h40, 32'h000, 0, 1, 0, 32'h40, 32'h000, 32'hA000_0010);
    // Fill to DEPTH while mem_read keeps the port busy.
    tbl[5]  = mk(1, 1, 0, 32'h10, 32'h101, 0, 0, 0, 32'h00, 32'h000, 32'h0);
    tbl[6]  = mk(1, 1, 0, 32'h14, 32'h102, 0, 0, 0, 32'h00, 32'h000, 32'h0);
    tbl[7]  = mk(1, 1, 0, 32'h18, 32'h103, 0, 0, 0, 32'h00, 32'h000, 32'h0);
    tbl[8]  = mk(1, 1, 0, 32'h1C, 32'h104, 0, 0, 0, 32'h00, 32'h000, 32'h0);
    tbl[9]  = mk(1, 1, 0, 32'h20, 32'h105, 1, 0, 1, 32'h10, 32'h101, 32'h0);
    tbl[10] = mk(1, 1, 0, 32'h20, 32'h105, 0, 0, 0, 32'h00, 32'h000, 32'h0);
    tbl[11] = mk(1, 0, 0, 32'h60, 32'h000, 0, 1, 0, 32'h60, 32'h000, 32'hA000_0018);
    tbl[12] = mk(0, 0, 0, 32'h00, 32'h000, 0, 0, 1, 32'h14, 32'h102, 32'h0);
    tbl[13] = mk(0, 0, 1, 32'h00, 32'h000, 1, 0, 1, 32'h18, 32'h103, 32'h0);
    tbl[14] = mk(0, 0, 1, 32'h00, 32'h000, 1, 0, 1, 32'h1C, 32'h104, 32'h0);
    tbl[15] = mk(0, 0, 1, 32'h00, 32'h000, 1, 0, 1, 32'h20, 32'h105, 32'h0);
    tbl[16] = mk(0, 0, 1, 32'h00, 32'h000, 0, 0, 0, 32'h00, 32'h000, 32'h0);
    tbl[17] = mk(0, 0, 0, 32'h00, 32'h000, 0, 0, 0, 32'h00, 32'h000, 32'h0);

    rst           = 1'b1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.flush     = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    #2;
    chk_all("reset", 0, 0, 0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].fl, tbl[i].a, tbl[i].d);
      chk_all($sformatf("row%0d", i), tbl[i].stall, tbl[i].drf, tbl[i].dwf,
              tbl[i].daddr, tbl[i].val, tbl[i].rdata);
    end

    // Two stores to the same word, then loads of that word.
    drive(1, 1, 0, 32'h04, 32'hA);
    chk_all("fw_st0", 0, 0, 0, 32'h0, 32'h0, 32'h0);
    drive(1, 1, 0, 32'h04, 32'hB);
    chk_all("fw_st1", 0, 0, 0, 32'h0, 32'h0, 32'h0);
`ifdef SB_FORWARD_EN
    drive(1, 0, 0, 32'h04, 32'h0);
    chk_all("fw_ld0", 0, 1, 0, 32'h04, 32'h0, 32'hB);
    drive(1, 0, 0, 32'h04, 32'h0);
    chk_all("fw_ld1", 0, 1, 0, 32'h04, 32'h0, 32'hB);
    drive(0, 0, 0, 32'h00, 32'h0);
    chk_all("fw_dr0", 0, 0, 1, 32'h04, 32'hA, 32'h0);
    drive(0, 0, 0, 32'h00, 32'h0);
    chk_all("fw_dr1", 0, 0, 1, 32'h04, 32'hB, 32'h0);
`else
    drive(1, 0, 0, 32'h04, 32'h0);
    chk_all("nf_ld0", 1, 0, 1, 32'h04, 32'hA, 32'h0);
    drive(1, 0, 0, 32'h04, 32'h0);
    chk_all("nf_ld1", 1, 0, 1, 32'h04, 32'hB, 32'h0);
    drive(1, 0, 0, 32'h04, 32'h0);
    chk_all("nf_ld2", 0, 1, 0, 32'h04, 32'h0, 32'hB);
`endif
    drive(0, 0, 0, 32'h00, 32'h0);
    chk_all("fw_idle", 0, 0, 0, 32'h0, 32'h0, 32'h0);

    // Asynchronous reset between edges with two entries buffered.
    drive(1, 1, 0, 32'h30, 32'hC1);
    drive(1, 1, 0, 32'h34, 32'hC2);
    drive(0, 0, 0, 32'h00, 32'h0);
    chk_all("ar_pre", 0, 0, 1, 32'h30, 32'hC1, 32'h0);
    rst = 1'b1;
    #1;
    chk_all("ar_rst", 0, 0, 0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 32'h00, 32'h0);
      chk_all($sformatf("ar_post%0d", i), 0, 0, 0, 32'h0, 32'h0, 32'h0);
    end
    chk("ar_no_write_c", 32'(wr_mask[12]), 32'h0);
    chk("ar_no_write_d", 32'(wr_mask[13]), 32'h0);

    @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
